// File: rtl/tick_div_pkg.sv
// Shared types and standard divisor constants for the tick divider bank.
package tick_div_pkg;

  localparam int unsigned DIV_W_DEF  = 27;
  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned CH_W_DEF   = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

  typedef logic [DIV_W_DEF-1:0] div_t;
  typedef logic [CH_W_DEF-1:0]  ch_idx_t;

  localparam div_t DIV_95HZ = div_t'(1048576);
  localparam div_t DIV_32HZ = div_t'(3145728);
  localparam div_t DIV_16HZ = div_t'(6291456);
  localparam div_t DIV_8HZ  = div_t'(12500000);
  localparam div_t DIV_2HZ  = div_t'(50000000);
  localparam div_t DIV_1HZ  = div_t'(100000000);

endpackage

// File: rtl/tick_div_channel.sv
// One clock-enable channel: period counter with glitch-free divisor update,
// registered tick strobe and square wave.
module tick_div_channel #(
  parameter int unsigned       DIV_W   = 27,
  parameter logic [DIV_W-1:0]  DEF_DIV = '1
) (
  input  logic             clk_main,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  logic [DIV_W-1:0] cnt_q,  cnt_d;
  logic [DIV_W-1:0] act_q,  act_d;
  logic [DIV_W-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             sq_q,   sq_d;
  logic             run;
  logic             at_end;
  logic [DIV_W:0]   thr;

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    sq_d   = 1'b0;
    thr    = '0;
    run    = (act_q != '0);
    at_end = run && (cnt_q == act_q - 1'b1);

    if (!en) begin
      cnt_d = '0;
      if (wr) begin
        act_d  = wr_div;
        pend_d = 1'b0;
      end
    end else if (sync || !run || at_end) begin
      // Sync, halt and wrap all restart at 0; a same-cycle write bypasses div_pend.
      cnt_d = '0;
      if (wr) begin
        act_d  = wr_div;
        pend_d = 1'b0;
      end else if (pend_q && (sync || at_end)) begin
        act_d  = pdiv_q;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (wr) begin
        pdiv_d = wr_div;
        pend_d = 1'b1;
      end
    end

    // Outputs are registered from the next state so they line up with cnt.
    thr = ({1'b0, act_d} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    if (en && (act_d != '0)) begin
      tick_d = !sync && (cnt_d == act_d - 1'b1);
      sq_d   = ({1'b0, cnt_d} >= thr);
    end
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      cnt_q  <= '0;
      act_q  <= DEF_DIV;
      pdiv_q <= '0;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;
  assign pend = pend_q;

endmodule

// File: rtl/tick_divider_bank.sv
// Bank of NUM_CH clock-enable generators in the clk_main domain with a
// shared divisor configuration port.
module tick_divider_bank
  import tick_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = NUM_CH_DEF,
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned DEF_DIV = DIV_95HZ,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_pulse,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  logic cfg_ack_q, cfg_ack_d;
  logic cfg_err_q, cfg_err_d;
  logic ch_ok;

  always_comb begin
    ch_ok     = (32'(cfg_ch) < NUM_CH);
    cfg_ack_d = cfg_we;
    cfg_err_d = cfg_we && !ch_ok;
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_ack_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_ack = cfg_ack_q;
  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_hit;
    assign wr_hit = cfg_we && ch_ok && (32'(cfg_ch) == i);

    tick_div_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DIV_W'(DEF_DIV))
    ) u_ch (
      .clk_main (clk_main),
      .reset    (reset),
      .en       (ch_en[i]),
      .sync     (sync_pulse),
      .wr       (wr_hit),
      .wr_div   (cfg_div),
      .tick     (tick[i]),
      .sq       (sq[i]),
      .pend     (pend[i])
    );
  end

endmodule

// File: tb/tb_tick_divider_bank.sv
// Randomized bench for tick_divider_bank with a behavioural period model and
// hand-computed directed checks.
module tb_tick_divider_bank;

  localparam int NCH  = 3;
  localparam int DW   = 27;
  localparam int DEFD = 4;

  logic           clk_main = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] ch_en = '1;
  logic           sync_pulse = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [DW-1:0]  cfg_div = '0;
  logic           cfg_ack, cfg_err;
  logic [NCH-1:0] pend, tick, sq;

  tick_divider_bank #(.NUM_CH(NCH), .DIV_W(DW), .DEF_DIV(DEFD)) dut (
    .clk_main   (clk_main),
    .reset      (reset),
    .ch_en      (ch_en),
    .sync_pulse (sync_pulse),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .pend       (pend),
    .tick       (tick),
    .sq         (sq)
  );

  always #5 clk_main = ~clk_main;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  bit chk_on = 0;

  // Model: position within the current period, active/pending divisor.
  int unsigned m_cnt [NCH];
  int unsigned m_act [NCH];
  int unsigned m_pdiv[NCH];
  bit          m_pend[NCH];
  bit          m_tick[NCH];
  bit          m_sq  [NCH];
  bit          m_ack, m_err;

  task automatic check(string name, int ch, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s ch%0d k=%0d: got %0h expected %0h", name, ch, k, got, exp);
    end
  endtask

  always @(posedge clk_main) begin : model
    bit wr;
    bit restart;
    m_ack = !reset && cfg_we;
    m_err = !reset && cfg_we && (int'(cfg_ch) >= NCH);
    for (int c = 0; c < NCH; c++) begin
      wr = cfg_we && (int'(cfg_ch) == c);
      if (reset) begin
        m_cnt[c] = 0; m_act[c] = DEFD; m_pdiv[c] = 0; m_pend[c] = 0;
        m_tick[c] = 0; m_sq[c] = 0;
      end else if (!ch_en[c]) begin
        m_cnt[c] = 0;
        if (wr) begin m_act[c] = cfg_div; m_pend[c] = 0; end
        m_tick[c] = 0; m_sq[c] = 0;
      end else begin
        restart = sync_pulse || (m_act[c] != 0 && m_cnt[c] == m_act[c] - 1);
        if (m_act[c] == 0 && !sync_pulse) begin
          m_cnt[c] = 0;
          if (wr) begin m_act[c] = cfg_div; m_pend[c] = 0; end
        end else if (restart) begin
          m_cnt[c] = 0;
          if (wr) m_act[c] = cfg_div;
          else if (m_pend[c]) m_act[c] = m_pdiv[c];
          m_pend[c] = 0;
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
          if (wr) begin m_pdiv[c] = cfg_div; m_pend[c] = 1; end
        end
        m_tick[c] = !sync_pulse && m_act[c] != 0 && m_cnt[c] == m_act[c] - 1;
        m_sq[c]   = m_act[c] != 0 && m_cnt[c] >= (m_act[c] + 1) / 2;
      end
    end
  end

  always @(negedge clk_main) begin
    if (chk_on) begin
      check("cfg_ack", 0, 32'(cfg_ack), 32'(m_ack));
      check("cfg_err", 0, 32'(cfg_err), 32'(m_err));
      for (int c = 0; c < NCH; c++) begin
        check("tick", c, 32'(tick[c]), 32'(m_tick[c]));
        check("sq",   c, 32'(sq[c]),   32'(m_sq[c]));
        check("pend", c, 32'(pend[c]), 32'(m_pend[c]));
      end
    end
  end

  task automatic nxt();
    @(negedge clk_main);
    k++;
  endtask

  task automatic goto(int t);
    while (k < t) nxt();
  endtask

  task automatic wr_cfg(int ch, int unsigned d);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = DW'(d);
  endtask

  initial begin
    int nt;
    reset = 1'b1; ch_en = '1;
    repeat (3) @(negedge clk_main);
    chk_on = 1;
    k = 0;
    reset = 1'b0;

    // Default divisor 4: ticks at cycles 3,7,11; sq 0,0,1,1.
    check("rst_pend", 0, 32'(pend), 0);
    check("rst_ack",  0, 32'(cfg_ack), 0);
    for (int t = 0; t <= 11; t++) begin
      goto(t);
      for (int c = 0; c < NCH; c++) begin
        check("A_tick", c, 32'(tick[c]), 32'(t % 4 == 3));
        check("A_sq",   c, 32'(sq[c]),   32'(t % 4 >= 2));
      end
    end

    // Mid-period write: pending until the next wrap.
    goto(13); wr_cfg(0, 6);
    goto(14); cfg_we = 0;
    check("B_pend", 0, 32'(pend[0]), 1);
    check("B_ack",  0, 32'(cfg_ack), 1);
    check("B_err",  0, 32'(cfg_err), 0);
    goto(15);
    check("B_tick_old", 0, 32'(tick[0]), 1);
    goto(16);
    check("B_pend_clr", 0, 32'(pend[0]), 0);
    for (int t = 17; t <= 21; t++) begin
      goto(t); check("B_tick_new", 0, 32'(tick[0]), 32'(t == 21));
    end

    // Write coincident with wrap: applied at once, no pending.
    goto(23);
    check("C_tick", 1, 32'(tick[1]), 1);
    wr_cfg(1, 3);
    goto(24); cfg_we = 0;
    check("C_pend", 1, 32'(pend[1]), 0);
    goto(25); check("C_tick", 1, 32'(tick[1]), 0);
    goto(26); check("C_tick", 1, 32'(tick[1]), 1);
    check("C_pend", 1, 32'(pend[1]), 0);

    // Two D=5 channels at different phases, then sync on a ch2 wrap.
    goto(27); wr_cfg(2, 5);
    goto(28); wr_cfg(1, 5);
    goto(29); cfg_we = 0;
    check("D_pend", 1, 32'(pend[1]), 1);
    goto(32); check("D_tick", 2, 32'(tick[2]), 1);
    goto(34); check("D_tick", 1, 32'(tick[1]), 1);
    goto(37); sync_pulse = 1;
    goto(38); sync_pulse = 0;
    for (int t = 38; t <= 42; t++) begin
      goto(t);
      check("D_sync", 1, 32'(tick[1]), 32'(t == 42));
      check("D_sync", 2, 32'(tick[2]), 32'(t == 42));
    end

    // Out-of-range channel index.
    goto(44); wr_cfg(3, 9);
    goto(45); cfg_we = 0;
    check("E_ack", 0, 32'(cfg_ack), 1);
    check("E_err", 0, 32'(cfg_err), 1);
    check("E_pend", 0, 32'(pend), 0);
    goto(46); check("E_ack_low", 0, 32'(cfg_ack), 0);
    goto(49); check("E_tick", 0, 32'(tick[0]), 1);

    // Write 0 to a running channel: one last tick then halted.
    goto(50); wr_cfg(0, 0);
    goto(51); cfg_we = 0;
    check("F_pend", 0, 32'(pend[0]), 1);
    nt = 0;
    for (int t = 51; t <= 62; t++) begin
      goto(t);
      if (tick[0]) nt++;
      if (t >= 56) begin
        check("F_halt_tick", 0, 32'(tick[0]), 0);
        check("F_halt_sq",   0, 32'(sq[0]),   0);
      end
    end
    check("F_final_ticks", 0, 32'(nt), 1);
    goto(63); wr_cfg(0, 2);
    goto(64); cfg_we = 0;
    check("F_load", 0, 32'(tick[0]), 0);
    check("F_pend", 0, 32'(pend[0]), 0);
    goto(65); check("F_load", 0, 32'(tick[0]), 1);
    goto(66); check("F_load", 0, 32'(tick[0]), 0);
    goto(67); check("F_load", 0, 32'(tick[0]), 1);

    // Reset mid-period restores the default divisor.
    goto(68); reset = 1;
    goto(69); reset = 0;
    check("G_tick", 0, 32'(tick), 0);
    check("G_sq",   0, 32'(sq), 0);
    check("G_pend", 0, 32'(pend), 0);
    goto(71); check("G_tick", 0, 32'(tick), 0);
    goto(72); check("G_tick", 0, 32'(tick), 32'(3'b111));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      nxt();
      reset      = ($urandom_range(0, 399) == 0);
      sync_pulse = ($urandom_range(0, 29) == 0);
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_div    = DW'($urandom_range(0, 9));
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 24) == 0) ch_en[c] = ~ch_en[c];
    end
    nxt();
    reset = 0; sync_pulse = 0; cfg_we = 0;
    nxt(); nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
